// File: rtl/skin_mask_tracker_pkg.sv
// Shared definitions for the skin-mask tracker: image defaults, field widths, mask bit, FSM states.
// The DIV state exists only when SKIN_TRACK_CENTROID_EN is defined.
package skin_mask_tracker_pkg;

    localparam int IMG_W_DEF   = 640;
    localparam int IMG_H_DEF   = 480;
    localparam int XW_DEF      = 10;
    localparam int YW_DEF      = 10;
    localparam int CNT_W_DEF   = 19;
    localparam int MIN_PIX_DEF = 64;
    localparam int SKIN_BIT    = 7;

`ifdef SKIN_TRACK_CENTROID_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_LATCH  = 3'd2,
        ST_DONE   = 3'd3,
        ST_DIV    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LATCH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/skin_mask_tracker_divider.sv
// Restoring unsigned divider, one quotient bit per clock; a zero divisor yields a zero quotient.
// Quotient is valid from the done pulse until the next start.
module seq_divider #(
    parameter int DIVIDEND_W = 29,
    parameter int DIVISOR_W  = 19,
    parameter int QUOT_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient
);

    localparam int STEP_W = $clog2(DIVIDEND_W + 1);

    logic                  load;
    logic [STEP_W-1:0]     steps_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic                  zero_q;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic                  ge;

    assign load = start & ~busy;

    always_comb begin
        shifted = {rem_q, quo_q[DIVIDEND_W-1]};
        ge      = (shifted >= {1'b0, dsr_q});
        rem_nxt = ge ? DIVISOR_W'(shifted - {1'b0, dsr_q}) : shifted[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            steps_q <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                busy    <= 1'b1;
                steps_q <= STEP_W'(DIVIDEND_W);
            end else if (busy) begin
                steps_q <= steps_q - STEP_W'(1);
                if (steps_q == STEP_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // dividend shifts out MSB-first while quotient bits shift in from the bottom
    always_ff @(posedge clk) begin
        if (load) begin
            rem_q  <= '0;
            dsr_q  <= divisor;
            quo_q  <= dividend;
            zero_q <= (divisor == '0);
        end else if (busy) begin
            rem_q <= rem_nxt;
            quo_q <= {quo_q[DIVIDEND_W-2:0], ge};
        end
    end

    assign quotient = zero_q ? '0 : quo_q[QUOT_W-1:0];

endmodule

// File: rtl/skin_mask_tracker.sv
// Per-frame bounding box and skin-pixel count from a binary skin mask; one result pulse per frame.
// Define SKIN_TRACK_CENTROID_EN to add sum accumulators, two seq_divider instances and centroid outputs.
module skin_mask_tracker
    import skin_mask_tracker_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int XW      = XW_DEF,
    parameter int YW      = YW_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vsync,
    input  logic             in_de,
    input  logic [7:0]       in_binary,
    output logic [XW-1:0]    box_x_min,
    output logic [XW-1:0]    box_x_max,
    output logic [YW-1:0]    box_y_min,
    output logic [YW-1:0]    box_y_max,
    output logic [CNT_W-1:0] obj_count,
    output logic             obj_valid,
`ifdef SKIN_TRACK_CENTROID_EN
    output logic [XW-1:0]    centroid_x,
    output logic [YW-1:0]    centroid_y,
`endif
    output logic             result_valid
);

    localparam logic [XW-1:0]    X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

    function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
        return (v >= X_LAST) ? X_LAST : v + XW'(1);
    endfunction

    function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
        return (v >= Y_LAST) ? Y_LAST : v + YW'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    state_t state_q, state_nxt;
    logic   vsync_d, de_d;
    logic   vsync_rise, de_fall, hit;
    logic   load_out;
    logic   obj_ok;
    logic   unused_bits;

    logic [XW-1:0]    x_p0, acc_xmin_p0, acc_xmax_p0, xmin_nxt, xmax_nxt;
    logic [YW-1:0]    y_p0, acc_ymin_p0, acc_ymax_p0, ymin_nxt, ymax_nxt;
    logic [CNT_W-1:0] acc_cnt_p0, cnt_nxt;

    logic [XW-1:0]    snap_xmin_p1, snap_xmax_p1;
    logic [YW-1:0]    snap_ymin_p1, snap_ymax_p1;
    logic [CNT_W-1:0] snap_cnt_p1;

`ifdef SKIN_TRACK_CENTROID_EN
    localparam int SX_W  = CNT_W + XW;
    localparam int SY_W  = CNT_W + YW;
    localparam int DIV_W = CNT_W + ((XW > YW) ? XW : YW);

    logic [SX_W-1:0] acc_sumx_p0, sumx_nxt, snap_sumx_p1;
    logic [SY_W-1:0] acc_sumy_p0, sumy_nxt, snap_sumy_p1;
    logic            div_start;
    logic            busy_x, busy_y, done_x, done_y;
    logic [XW-1:0]   quot_x;
    logic [YW-1:0]   quot_y;
`endif

    assign vsync_rise  = in_vsync & ~vsync_d;
    assign de_fall     = de_d & ~in_de;
    assign hit         = in_de & in_binary[SKIN_BIT];
    assign unused_bits = ^in_binary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
            de_d    <= 1'b0;
            x_p0    <= '0;
            y_p0    <= '0;
        end else begin
            vsync_d <= in_vsync;
            de_d    <= in_de;
            if (vsync_rise) begin
                x_p0 <= '0;
                y_p0 <= '0;
            end else if (de_fall) begin
                x_p0 <= '0;
                y_p0 <= sat_inc_y(y_p0);
            end else if (in_de) begin
                x_p0 <= sat_inc_x(x_p0);
            end
        end
    end

    // stage 0: running accumulators, including a hit that coincides with the vsync rise
    always_comb begin
        cnt_nxt  = acc_cnt_p0;
        xmin_nxt = acc_xmin_p0;
        xmax_nxt = acc_xmax_p0;
        ymin_nxt = acc_ymin_p0;
        ymax_nxt = acc_ymax_p0;
`ifdef SKIN_TRACK_CENTROID_EN
        sumx_nxt = acc_sumx_p0;
        sumy_nxt = acc_sumy_p0;
`endif
        if (hit) begin
            cnt_nxt  = sat_inc_cnt(acc_cnt_p0);
            xmin_nxt = (x_p0 < acc_xmin_p0) ? x_p0 : acc_xmin_p0;
            xmax_nxt = (x_p0 > acc_xmax_p0) ? x_p0 : acc_xmax_p0;
            ymin_nxt = (y_p0 < acc_ymin_p0) ? y_p0 : acc_ymin_p0;
            ymax_nxt = (y_p0 > acc_ymax_p0) ? y_p0 : acc_ymax_p0;
`ifdef SKIN_TRACK_CENTROID_EN
            sumx_nxt = acc_sumx_p0 + SX_W'(x_p0);
            sumy_nxt = acc_sumy_p0 + SY_W'(y_p0);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_p0  <= '0;
            acc_xmin_p0 <= '0;
            acc_xmax_p0 <= '0;
            acc_ymin_p0 <= '0;
            acc_ymax_p0 <= '0;
`ifdef SKIN_TRACK_CENTROID_EN
            acc_sumx_p0 <= '0;
            acc_sumy_p0 <= '0;
`endif
        end else if (vsync_rise) begin
            acc_cnt_p0  <= '0;
            acc_xmin_p0 <= X_LAST;
            acc_xmax_p0 <= '0;
            acc_ymin_p0 <= Y_LAST;
            acc_ymax_p0 <= '0;
`ifdef SKIN_TRACK_CENTROID_EN
            acc_sumx_p0 <= '0;
            acc_sumy_p0 <= '0;
`endif
        end else begin
            acc_cnt_p0  <= cnt_nxt;
            acc_xmin_p0 <= xmin_nxt;
            acc_xmax_p0 <= xmax_nxt;
            acc_ymin_p0 <= ymin_nxt;
            acc_ymax_p0 <= ymax_nxt;
`ifdef SKIN_TRACK_CENTROID_EN
            acc_sumx_p0 <= sumx_nxt;
            acc_sumy_p0 <= sumy_nxt;
`endif
        end
    end

    // stage 1: frame snapshot, taken only while a frame is being tracked
    always_ff @(posedge clk) begin
        if (vsync_rise && state_q == ST_ACTIVE) begin
            snap_cnt_p1  <= cnt_nxt;
            snap_xmin_p1 <= xmin_nxt;
            snap_xmax_p1 <= xmax_nxt;
            snap_ymin_p1 <= ymin_nxt;
            snap_ymax_p1 <= ymax_nxt;
`ifdef SKIN_TRACK_CENTROID_EN
            snap_sumx_p1 <= sumx_nxt;
            snap_sumy_p1 <= sumy_nxt;
`endif
        end
    end

`ifdef SKIN_TRACK_CENTROID_EN
    seq_divider #(
        .DIVIDEND_W (DIV_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (XW)
    ) u_div_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIV_W'(snap_sumx_p1)),
        .divisor  (snap_cnt_p1),
        .busy     (busy_x),
        .done     (done_x),
        .quotient (quot_x)
    );

    seq_divider #(
        .DIVIDEND_W (DIV_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (YW)
    ) u_div_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIV_W'(snap_sumy_p1)),
        .divisor  (snap_cnt_p1),
        .busy     (busy_y),
        .done     (done_y),
        .quotient (quot_y)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        load_out  = 1'b0;
`ifdef SKIN_TRACK_CENTROID_EN
        div_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE:   if (vsync_rise) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (vsync_rise) state_nxt = ST_LATCH;
            ST_LATCH: begin
`ifdef SKIN_TRACK_CENTROID_EN
                if (!busy_x && !busy_y) begin
                    div_start = 1'b1;
                    state_nxt = ST_DIV;
                end
`else
                load_out  = 1'b1;
                state_nxt = ST_DONE;
`endif
            end
`ifdef SKIN_TRACK_CENTROID_EN
            ST_DIV: begin
                if (done_x && done_y) begin
                    load_out  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE:   state_nxt = ST_ACTIVE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign obj_ok = (snap_cnt_p1 >= MIN_CNT);

    // stage 2: published results, held until the next frame's pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            obj_valid    <= 1'b0;
            obj_count    <= '0;
            box_x_min    <= '0;
            box_x_max    <= '0;
            box_y_min    <= '0;
            box_y_max    <= '0;
`ifdef SKIN_TRACK_CENTROID_EN
            centroid_x   <= '0;
            centroid_y   <= '0;
`endif
        end else begin
            result_valid <= load_out;
            if (load_out) begin
                obj_count <= snap_cnt_p1;
                obj_valid <= obj_ok;
                box_x_min <= obj_ok ? snap_xmin_p1 : '0;
                box_x_max <= obj_ok ? snap_xmax_p1 : '0;
                box_y_min <= obj_ok ? snap_ymin_p1 : '0;
                box_y_max <= obj_ok ? snap_ymax_p1 : '0;
`ifdef SKIN_TRACK_CENTROID_EN
                centroid_x <= obj_ok ? quot_x : '0;
                centroid_y <= obj_ok ? quot_y : '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_skin_mask_tracker.sv
// Directed-plus-random bench for skin_mask_tracker on a 16x8 image; follows SKIN_TRACK_CENTROID_EN.
// Expected results come from a frame-level model over the driven pixel map.
module tb_skin_mask_tracker;

    localparam int IMG_W   = 16;
    localparam int IMG_H   = 8;
    localparam int XW      = 10;
    localparam int YW      = 10;
    localparam int CNT_W   = 19;
    localparam int MIN_PIX = 4;
    localparam int MAXC    = 24;
`ifdef SKIN_TRACK_CENTROID_EN
    localparam int LAT = 2 + (CNT_W + XW) + 1;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vsync;
    logic             in_de;
    logic [7:0]       in_binary;
    logic [XW-1:0]    box_x_min, box_x_max;
    logic [YW-1:0]    box_y_min, box_y_max;
    logic [CNT_W-1:0] obj_count;
    logic             obj_valid;
    logic             result_valid;
`ifdef SKIN_TRACK_CENTROID_EN
    logic [XW-1:0]    centroid_x;
    logic [YW-1:0]    centroid_y;
`endif

    int checks = 0;
    int errors = 0;
    bit pix [IMG_H][MAXC];
    int line_len = IMG_W;
    bit tail_pending = 1'b0;
    int e_cnt, e_valid, e_xmin, e_xmax, e_ymin, e_ymax, e_cx, e_cy;

    always #5 clk = ~clk;

    skin_mask_tracker #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .XW      (XW),
        .YW      (YW),
        .CNT_W   (CNT_W),
        .MIN_PIX (MIN_PIX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vsync     (in_vsync),
        .in_de        (in_de),
        .in_binary    (in_binary),
        .box_x_min    (box_x_min),
        .box_x_max    (box_x_max),
        .box_y_min    (box_y_min),
        .box_y_max    (box_y_max),
        .obj_count    (obj_count),
        .obj_valid    (obj_valid),
`ifdef SKIN_TRACK_CENTROID_EN
        .centroid_x   (centroid_x),
        .centroid_y   (centroid_y),
`endif
        .result_valid (result_valid)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".count"},     32'(obj_count), e_cnt);
        check({tag, ".obj_valid"}, 32'(obj_valid), e_valid);
        check({tag, ".x_min"},     32'(box_x_min), e_xmin);
        check({tag, ".x_max"},     32'(box_x_max), e_xmax);
        check({tag, ".y_min"},     32'(box_y_min), e_ymin);
        check({tag, ".y_max"},     32'(box_y_max), e_ymax);
`ifdef SKIN_TRACK_CENTROID_EN
        check({tag, ".cent_x"},    32'(centroid_x), e_cx);
        check({tag, ".cent_y"},    32'(centroid_y), e_cy);
`endif
    endtask

    task automatic clear_expected();
        e_cnt = 0; e_valid = 0; e_xmin = 0; e_xmax = 0;
        e_ymin = 0; e_ymax = 0; e_cx = 0; e_cy = 0;
    endtask

    task automatic clear_pix();
        for (int l = 0; l < IMG_H; l++)
            for (int c = 0; c < MAXC; c++) pix[l][c] = 1'b0;
    endtask

    task automatic fill_block(input int x0, input int x1, input int y0, input int y1);
        for (int l = y0; l <= y1; l++)
            for (int c = x0; c <= x1; c++) pix[l][c] = 1'b1;
    endtask

    task automatic fill_random(input int pct);
        for (int l = 0; l < IMG_H; l++)
            for (int c = 0; c < MAXC; c++) pix[l][c] = ($urandom_range(0, 99) < pct);
    endtask

    // Columns past the line width all land on the last column; results blank below MIN_PIX.
    task automatic compute_expected();
        int cnt = 0;
        int xmn = IMG_W - 1, xmx = 0, ymn = IMG_H - 1, ymx = 0;
        int sx = 0, sy = 0;
        int xe;
        for (int l = 0; l < IMG_H; l++)
            for (int c = 0; c < line_len; c++)
                if (pix[l][c]) begin
                    xe = (c < IMG_W) ? c : IMG_W - 1;
                    cnt++;
                    sx += xe;
                    sy += l;
                    if (xe < xmn) xmn = xe;
                    if (xe > xmx) xmx = xe;
                    if (l < ymn) ymn = l;
                    if (l > ymx) ymx = l;
                end
        clear_expected();
        e_cnt = cnt;
        if (cnt >= MIN_PIX) begin
            e_valid = 1;
            e_xmin = xmn; e_xmax = xmx; e_ymin = ymn; e_ymax = ymx;
            e_cx = sx / cnt; e_cy = sy / cnt;
        end
    endtask

    task automatic drive_lines(input int l0, input int l1, input bit tail);
        for (int l = l0; l <= l1; l++) begin
            for (int c = 0; c < line_len; c++) begin
                in_de = 1'b1;
                in_binary = pix[l][c] ? {1'b1, 7'($urandom)} : {1'b0, 7'($urandom)};
                if (tail && l == l1 && c == line_len - 1) begin
                    in_vsync = 1'b1;
                    tail_pending = 1'b1;
                    return;
                end
                @(negedge clk);
            end
            in_de = 1'b0;
            in_binary = 8'h00;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic drive_frame(input bit tail);
        check_outputs("hold");
        in_vsync = 1'b0;
        in_de = 1'b0;
        repeat (2) @(negedge clk);
        drive_lines(0, IMG_H - 1, tail);
    endtask

    task automatic end_frame(input bit expect_res, input bit inject);
        int first_m = 0;
        int pulses = 0;
        if (tail_pending) tail_pending = 1'b0;
        else begin
            in_vsync = 1'b1;
            in_de = 1'b0;
            in_binary = 8'h00;
        end
        for (int m = 1; m <= LAT + 4; m++) begin
            @(negedge clk);
            if (m == 1) begin in_de = 1'b0; in_binary = 8'h00; end
            if (inject) begin
                if (m == 6) in_vsync = 1'b0;
                if (m >= 7 && m <= 9) begin in_de = 1'b1; in_binary = 8'hFF; end
                if (m == 10) begin in_de = 1'b0; in_binary = 8'h00; end
                if (m == 12) in_vsync = 1'b1;
            end
            if (result_valid === 1'b1) begin
                pulses++;
                if (first_m == 0) first_m = m;
            end
        end
        if (expect_res) begin
            compute_expected();
            check("latency", first_m, LAT);
            check("pulses", pulses, 1);
            check_outputs("result");
        end else begin
            check("no_result", pulses, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_vsync = 1'b0;
        in_de = 1'b0;
        in_binary = 8'h00;
        clear_expected();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset.result_valid", 32'(result_valid), 0);
        rst_n = 1'b1;

        // empty frames: the partial one after reset yields nothing, the next reports zeros
        line_len = IMG_W;
        clear_pix();
        drive_frame(1'b0);
        end_frame(1'b0, 1'b0);
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);

        clear_pix();
        fill_block(3, 6, 2, 4);
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);
        check("blk.count", 32'(obj_count), 12);
        check("blk.x_min", 32'(box_x_min), 3);
        check("blk.y_max", 32'(box_y_max), 4);
`ifdef SKIN_TRACK_CENTROID_EN
        check("blk.cent_x", 32'(centroid_x), 4);
        check("blk.cent_y", 32'(centroid_y), 3);
`endif

        clear_pix();
        pix[7][15] = 1'b1;
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);
        check("single.obj_valid", 32'(obj_valid), 0);

        clear_pix();
        fill_block(0, 15, 0, 7);
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);
        check("full.count", 32'(obj_count), 128);

        line_len = 20;
        clear_pix();
        fill_block(16, 19, 1, 1);
        fill_block(16, 19, 5, 5);
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);
        check("sat.x_min", 32'(box_x_min), 15);
        line_len = IMG_W;

        // reset pulse in the middle of a frame
        fill_random(50);
        in_vsync = 1'b0;
        repeat (2) @(negedge clk);
        drive_lines(0, 3, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        clear_expected();
        check_outputs("midreset");
        check("midreset.result_valid", 32'(result_valid), 0);
        rst_n = 1'b1;
        drive_lines(4, 7, 1'b0);
        end_frame(1'b0, 1'b0);
        fill_random(40);
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);

        // last pixel arrives together with the vsync rise
        clear_pix();
        fill_block(0, 1, 0, 1);
        pix[7][15] = 1'b1;
        drive_frame(1'b1);
        end_frame(1'b1, 1'b0);
        check("tail.count", 32'(obj_count), 5);
        clear_pix();
        pix[3][5] = 1'b1;
        pix[4][9] = 1'b1;
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);
        check("after_tail.count", 32'(obj_count), 2);

        for (int i = 0; i < 4; i++) begin
            fill_random((i == 0) ? 2 : (i == 1) ? 25 : (i == 2) ? 60 : 95);
            drive_frame(1'b0);
            end_frame(1'b1, 1'b0);
        end

`ifdef SKIN_TRACK_CENTROID_EN
        // a short frame closing during the division is dropped
        clear_pix();
        fill_block(5, 9, 1, 6);
        drive_frame(1'b0);
        end_frame(1'b1, 1'b1);
        fill_random(30);
        drive_frame(1'b0);
        end_frame(1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
